// File: rtl/masked_arith_requester_if.sv
// Bus bundle for masked_arith_requester: seed, command, adder request/response,
// result and error signals. The master modport is the block's view; slave is the environment's.
interface masked_arith_requester_if #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned SHARES = 2
);
  localparam int unsigned RWIDTH = DWIDTH * SHARES * (SHARES - 1) / 2;
  localparam int unsigned SWIDTH = DWIDTH * SHARES;

  logic                  SeedValidxSI;
  logic [2*RWIDTH-1:0]   SeedxDI;
  logic                  CmdValidxSI;
  logic                  CmdReadyxSO;
  logic                  CmdSubtractxSI;
  logic [SWIDTH-1:0]     CmdOpAxDI;
  logic [SWIDTH-1:0]     CmdOpBxDI;
  logic                  ReqValidxSO;
  logic                  ReqReadyxSI;
  logic                  ReqSubtractxSO;
  logic [SWIDTH-1:0]     ReqIn1xDO;
  logic [SWIDTH-1:0]     ReqIn2xDO;
  logic [RWIDTH-1:0]     RandomDOM1xDO;
  logic [RWIDTH-1:0]     RandomDOM2xDO;
  logic                  RespValidxSI;
  logic [SWIDTH-1:0]     RespResultxDI;
  logic                  ResValidxSO;
  logic                  ResReadyxSI;
  logic [SWIDTH-1:0]     ResResultxDO;
  logic                  ErrTimeoutxSO;
  logic                  ErrProtocolxSO;
  logic                  ErrClearxSI;

  modport master (
    input  SeedValidxSI, SeedxDI, CmdValidxSI, CmdSubtractxSI, CmdOpAxDI, CmdOpBxDI,
           ReqReadyxSI, RespValidxSI, RespResultxDI, ResReadyxSI, ErrClearxSI,
    output CmdReadyxSO, ReqValidxSO, ReqSubtractxSO, ReqIn1xDO, ReqIn2xDO,
           RandomDOM1xDO, RandomDOM2xDO, ResValidxSO, ResResultxDO,
           ErrTimeoutxSO, ErrProtocolxSO
  );

  modport slave (
    output SeedValidxSI, SeedxDI, CmdValidxSI, CmdSubtractxSI, CmdOpAxDI, CmdOpBxDI,
           ReqReadyxSI, RespValidxSI, RespResultxDI, ResReadyxSI, ErrClearxSI,
    input  CmdReadyxSO, ReqValidxSO, ReqSubtractxSO, ReqIn1xDO, ReqIn2xDO,
           RandomDOM1xDO, RandomDOM2xDO, ResValidxSO, ResResultxDO,
           ErrTimeoutxSO, ErrProtocolxSO
  );
endinterface

// File: rtl/masked_arith_requester.sv
// Sequences one masked add/subtract: registers shared operands, issues them to an external
// DOM adder with fresh PRNG randomness, waits a bounded time for the result, hands it on.
module masked_arith_requester #(
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned SHARES  = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input logic ClkxCI,
  input logic RstxBI,
  masked_arith_requester_if.master bus
);
  localparam int unsigned RWIDTH = DWIDTH * SHARES * (SHARES - 1) / 2;
  localparam int unsigned SWIDTH = DWIDTH * SHARES;
  localparam int unsigned PWIDTH = 2 * RWIDTH;
  localparam int unsigned NWORDS = PWIDTH / 32;
  localparam int unsigned CWIDTH = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [CWIDTH-1:0] cnt, cnt_nxt;
  logic              seeded;
  logic [PWIDTH-1:0] prng, prng_step, seed_fix;
  logic              cmd_ready, load_cmd, load_res, to_set, pe_set;
  logic              req_valid, res_valid, req_sub, err_to, err_pe;
  logic [SWIDTH-1:0] op_a, op_b, res;

  function automatic logic [31:0] xorshift32(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // Per-word PRNG step and seed sanitising (an all-zero word would lock xorshift at zero)
  for (genvar w = 0; w < NWORDS; w++) begin : g_word
    assign prng_step[32*w +: 32] = xorshift32(prng[32*w +: 32]);
    assign seed_fix[32*w +: 32]  = (bus.SeedxDI[32*w +: 32] == 32'd0) ? 32'd1
                                                                     : bus.SeedxDI[32*w +: 32];
  end

  assign cmd_ready = (state == S_IDLE) && seeded;

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load_cmd  = 1'b0;
    load_res  = 1'b0;
    to_set    = 1'b0;
    pe_set    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.CmdValidxSI && cmd_ready) begin
          load_cmd  = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.ReqReadyxSI) begin
          cnt_nxt   = '0;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt + CWIDTH'(1);
        // A response on the last allowed cycle still wins over the timeout
        if (bus.RespValidxSI) begin
          load_res  = 1'b1;
          state_nxt = S_DONE;
        end else if (cnt == CWIDTH'(TIMEOUT - 1)) begin
          to_set    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_DONE: begin
        if (bus.ResReadyxSI) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (bus.RespValidxSI && (state != S_WAIT)) pe_set = 1'b1;
  end

  // Registered outputs and share-wise datapath; shares are only ever moved, never combined
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      req_valid <= 1'b0;
      res_valid <= 1'b0;
      req_sub   <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      res       <= '0;
      err_to    <= 1'b0;
      err_pe    <= 1'b0;
    end else begin
      req_valid <= (state_nxt == S_ISSUE);
      res_valid <= (state_nxt == S_DONE);
      if (load_cmd) begin
        req_sub <= bus.CmdSubtractxSI;
        op_a    <= bus.CmdOpAxDI;
        op_b    <= bus.CmdOpBxDI;
      end
      if (load_res) res <= bus.RespResultxDI;
      if (to_set)               err_to <= 1'b1;
      else if (bus.ErrClearxSI) err_to <= 1'b0;
      if (pe_set)               err_pe <= 1'b1;
      else if (bus.ErrClearxSI) err_pe <= 1'b0;
    end
  end

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      prng   <= '0;
      seeded <= 1'b0;
    end else if (bus.SeedValidxSI) begin
      prng   <= seed_fix;
      seeded <= 1'b1;
    end else if (seeded) begin
      prng <= prng_step;
    end
  end

  assign bus.CmdReadyxSO    = cmd_ready;
  assign bus.ReqValidxSO    = req_valid;
  assign bus.ReqSubtractxSO = req_sub;
  assign bus.ReqIn1xDO      = op_a;
  assign bus.ReqIn2xDO      = op_b;
  assign bus.RandomDOM1xDO  = prng[RWIDTH-1:0];
  assign bus.RandomDOM2xDO  = prng[PWIDTH-1:RWIDTH];
  assign bus.ResValidxSO    = res_valid;
  assign bus.ResResultxDO   = res;
  assign bus.ErrTimeoutxSO  = err_to;
  assign bus.ErrProtocolxSO = err_pe;
endmodule

// File: tb/tb_masked_arith_requester.sv
// Scoreboard bench for masked_arith_requester: stimulus pushes expected requests and
// unmasked results; a negedge monitor checks every request and result handshake.
module tb_masked_arith_requester;
  localparam int unsigned DW = 32;
  localparam int unsigned SH = 2;
  localparam int unsigned RW = DW * SH * (SH - 1) / 2;
  localparam int unsigned SW = DW * SH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  masked_arith_requester_if #(.DWIDTH(DW), .SHARES(SH)) bus ();
  masked_arith_requester_if #(.DWIDTH(DW), .SHARES(SH)) bus_to ();

  masked_arith_requester #(.DWIDTH(DW), .SHARES(SH)) u_dut (
    .ClkxCI(clk), .RstxBI(rst_n), .bus(bus));
  masked_arith_requester #(.DWIDTH(DW), .SHARES(SH), .TIMEOUT(4)) u_dut_to (
    .ClkxCI(clk), .RstxBI(rst_n), .bus(bus_to));

  int n_cmp = 0;
  int n_bad = 0;

  logic          exp_sub[$];
  logic [SW-1:0] exp_a[$];
  logic [SW-1:0] exp_b[$];
  logic [DW-1:0] exp_val[$];
  logic [SW-1:0] exp_res[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: actual none required event", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  function automatic logic [DW-1:0] unmask(input logic [SW-1:0] v);
    logic [DW-1:0] r = '0;
    for (int j = 0; j < SH; j++) r ^= v[DW*j +: DW];
    return r;
  endfunction

  function automatic logic [SW-1:0] mask(input logic [DW-1:0] v);
    logic [SW-1:0] r;
    logic [DW-1:0] acc = v;
    for (int j = 1; j < SH; j++) begin
      r[DW*j +: DW] = DW'($urandom);
      acc ^= r[DW*j +: DW];
    end
    r[DW-1:0] = acc;
    return r;
  endfunction

  // Monitor: every request and result handshake is checked against the queues
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.ReqValidxSO && bus.ReqReadyxSI) begin
          if (exp_a.size() == 0) fail_now("req_unexpected");
          else begin
            chk("req_sub", 64'(bus.ReqSubtractxSO), 64'(exp_sub.pop_front()));
            chk("req_in1", bus.ReqIn1xDO, exp_a.pop_front());
            chk("req_in2", bus.ReqIn2xDO, exp_b.pop_front());
          end
        end
        if (bus.ResValidxSO && bus.ResReadyxSI) begin
          if (exp_res.size() == 0 || exp_val.size() == 0) fail_now("res_unexpected");
          else begin
            chk("res_shares", bus.ResResultxDO, exp_res.pop_front());
            chk("res_value", 64'(unmask(bus.ResResultxDO)), 64'(exp_val.pop_front()));
          end
        end
      end
    end
  end

  task automatic wait_ready();
    int guard = 0;
    while (!bus.CmdReadyxSO && guard < 200) begin
      step();
      guard++;
    end
    if (!bus.CmdReadyxSO) fail_now("cmd_ready_wait");
  endtask

  // One full transaction; the adder model computes on the offered request shares
  task automatic run_txn(input logic sub, input logic [SW-1:0] a, input logic [SW-1:0] b,
                         input int stall, input int dly, input int rdly);
    logic [SW-1:0] r1, r2, rs;
    logic [DW-1:0] val;
    wait_ready();
    bus.CmdValidxSI = 1'b1;
    bus.CmdSubtractxSI = sub;
    bus.CmdOpAxDI = a;
    bus.CmdOpBxDI = b;
    exp_sub.push_back(sub);
    exp_a.push_back(a);
    exp_b.push_back(b);
    exp_val.push_back(sub ? unmask(a) - unmask(b) : unmask(a) + unmask(b));
    step();
    bus.CmdValidxSI = 1'b0;
    bus.CmdSubtractxSI = ~sub;
    bus.CmdOpAxDI = {$urandom, $urandom};
    bus.CmdOpBxDI = {$urandom, $urandom};
    r1 = bus.ReqIn1xDO;
    r2 = bus.ReqIn2xDO;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("req_valid_stall", 64'(bus.ReqValidxSO), 64'd1);
      chk("req_in1_stable", bus.ReqIn1xDO, r1);
      chk("req_in2_stable", bus.ReqIn2xDO, r2);
      step();
    end
    bus.ReqReadyxSI = 1'b1;
    val = bus.ReqSubtractxSO ? unmask(bus.ReqIn1xDO) - unmask(bus.ReqIn2xDO)
                             : unmask(bus.ReqIn1xDO) + unmask(bus.ReqIn2xDO);
    step();
    bus.ReqReadyxSI = 1'b0;
    repeat (dly - 1) step();
    rs = mask(val);
    bus.RespValidxSI = 1'b1;
    bus.RespResultxDI = rs;
    exp_res.push_back(rs);
    step();
    bus.RespValidxSI = 1'b0;
    bus.RespResultxDI = {$urandom, $urandom};
    repeat (rdly) step();
    bus.ResReadyxSI = 1'b1;
    step();
    bus.ResReadyxSI = 1'b0;
  endtask

  task automatic seed_all(input logic [2*RW-1:0] s);
    bus.SeedxDI = s;
    bus.SeedValidxSI = 1'b1;
    bus_to.SeedxDI = {32'h0BAD_F00D, 32'h1357_9BDF};
    bus_to.SeedValidxSI = 1'b1;
    step();
    bus.SeedValidxSI = 1'b0;
    bus_to.SeedValidxSI = 1'b0;
  endtask

  initial begin
    logic [SW-1:0] d;
    bus.SeedValidxSI = 0; bus.SeedxDI = '0; bus.CmdValidxSI = 0; bus.CmdSubtractxSI = 0;
    bus.CmdOpAxDI = '0; bus.CmdOpBxDI = '0; bus.ReqReadyxSI = 0; bus.RespValidxSI = 0;
    bus.RespResultxDI = '0; bus.ResReadyxSI = 0; bus.ErrClearxSI = 0;
    bus_to.SeedValidxSI = 0; bus_to.SeedxDI = '0; bus_to.CmdValidxSI = 0;
    bus_to.CmdSubtractxSI = 0; bus_to.CmdOpAxDI = '0; bus_to.CmdOpBxDI = '0;
    bus_to.ReqReadyxSI = 1; bus_to.RespValidxSI = 0; bus_to.RespResultxDI = '0;
    bus_to.ResReadyxSI = 0; bus_to.ErrClearxSI = 0;

    repeat (3) step();
    chk("rst_cmd_ready", 64'(bus.CmdReadyxSO), 64'd0);
    chk("rst_req_valid", 64'(bus.ReqValidxSO), 64'd0);
    chk("rst_res_valid", 64'(bus.ResValidxSO), 64'd0);
    chk("rst_errs", {62'd0, bus.ErrTimeoutxSO, bus.ErrProtocolxSO}, 64'd0);
    chk("rst_random", {bus.RandomDOM2xDO, bus.RandomDOM1xDO}, 64'd0);
    chk("rst_result", bus.ResResultxDO, 64'd0);
    rst_n = 1'b1;

    // Unseeded: commands must be refused
    bus.CmdValidxSI = 1'b1;
    bus.CmdOpAxDI = {$urandom, $urandom};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("unseeded_cmd_ready", 64'(bus.CmdReadyxSO), 64'd0);
      chk("unseeded_req_valid", 64'(bus.ReqValidxSO), 64'd0);
      step();
    end
    bus.CmdValidxSI = 1'b0;

    // Seed with zero word 0, then watch the PRNG advance
    seed_all({32'h1234_5678, 32'h0000_0000});
    @(negedge clk);
    chk("prng_seed_w0", 64'(bus.RandomDOM1xDO), 64'h1);
    chk("prng_seed_w1", 64'(bus.RandomDOM2xDO), 64'h1234_5678);
    chk("seeded_cmd_ready", 64'(bus.CmdReadyxSO), 64'd1);
    step();
    @(negedge clk);
    chk("prng_step1_w0", 64'(bus.RandomDOM1xDO), 64'h0004_2021);
    chk("prng_step1_w1", 64'(bus.RandomDOM2xDO), 64'(xs(32'h1234_5678)));
    step();
    @(negedge clk);
    chk("prng_step2_w0", 64'(bus.RandomDOM1xDO), 64'(xs(32'h0004_2021)));

    // Protocol error in IDLE, clear, and set-over-clear priority
    step();
    bus.RespValidxSI = 1'b1;
    bus.RespResultxDI = {$urandom, $urandom};
    step();
    bus.RespValidxSI = 1'b0;
    @(negedge clk);
    chk("proto_err_set", 64'(bus.ErrProtocolxSO), 64'd1);
    chk("proto_res_valid", 64'(bus.ResValidxSO), 64'd0);
    chk("proto_still_idle", 64'(bus.CmdReadyxSO), 64'd1);
    chk("proto_data_ignored", bus.ResResultxDO, 64'd0);
    step();
    bus.ErrClearxSI = 1'b1;
    step();
    bus.ErrClearxSI = 1'b0;
    @(negedge clk);
    chk("proto_err_cleared", 64'(bus.ErrProtocolxSO), 64'd0);
    step();
    bus.RespValidxSI = 1'b1;
    bus.ErrClearxSI = 1'b1;
    step();
    bus.RespValidxSI = 1'b0;
    bus.ErrClearxSI = 1'b0;
    @(negedge clk);
    chk("proto_set_beats_clear", 64'(bus.ErrProtocolxSO), 64'd1);
    step();
    bus.ErrClearxSI = 1'b1;
    step();
    bus.ErrClearxSI = 1'b0;

    // Directed: 5 + 3 with a 3-cycle request stall and a 5-cycle adder latency
    run_txn(1'b0, {32'hA5A5_A5A0, 32'hA5A5_A5A5}, {32'h0F0F_0F0C, 32'h0F0F_0F0F}, 3, 5, 0);
    // Directed: 3 - 5 wraps
    run_txn(1'b1, mask(32'd3), mask(32'd5), 0, 1, 2);
    for (int i = 0; i < 30; i++)
      run_txn(1'($urandom), mask($urandom), mask($urandom), int'($urandom_range(0, 4)),
              int'($urandom_range(1, 20)), int'($urandom_range(0, 3)));

    // Timeout instance (TIMEOUT = 4): no response at all
    bus_to.CmdValidxSI = 1'b1;
    bus_to.CmdOpAxDI = mask($urandom);
    bus_to.CmdOpBxDI = mask($urandom);
    step();
    bus_to.CmdValidxSI = 1'b0;
    step();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("to_not_yet", 64'(bus_to.ErrTimeoutxSO), 64'd0);
      chk("to_busy", 64'(bus_to.CmdReadyxSO), 64'd0);
      step();
    end
    @(negedge clk);
    chk("to_err_set", 64'(bus_to.ErrTimeoutxSO), 64'd1);
    chk("to_back_idle", 64'(bus_to.CmdReadyxSO), 64'd1);
    chk("to_no_result", 64'(bus_to.ResValidxSO), 64'd0);
    step();
    bus_to.ErrClearxSI = 1'b1;
    step();
    bus_to.ErrClearxSI = 1'b0;
    @(negedge clk);
    chk("to_err_cleared", 64'(bus_to.ErrTimeoutxSO), 64'd0);

    // Response on the 4th WAIT cycle beats the timeout
    step();
    bus_to.CmdValidxSI = 1'b1;
    step();
    bus_to.CmdValidxSI = 1'b0;
    step();
    repeat (3) step();
    d = mask(32'hCAFE_0001);
    bus_to.RespValidxSI = 1'b1;
    bus_to.RespResultxDI = d;
    step();
    bus_to.RespValidxSI = 1'b0;
    @(negedge clk);
    chk("to_resp_wins_valid", 64'(bus_to.ResValidxSO), 64'd1);
    chk("to_resp_wins_err", 64'(bus_to.ErrTimeoutxSO), 64'd0);
    chk("to_resp_wins_data", bus_to.ResResultxDO, d);
    bus_to.ResReadyxSI = 1'b1;
    step();
    bus_to.ResReadyxSI = 1'b0;
    @(negedge clk);
    chk("to_done_to_idle", 64'(bus_to.CmdReadyxSO), 64'd1);

    // Reset in WAIT aborts the transaction
    wait_ready();
    bus.CmdValidxSI = 1'b1;
    bus.CmdSubtractxSI = 1'b0;
    bus.CmdOpAxDI = mask($urandom);
    bus.CmdOpBxDI = mask($urandom);
    exp_sub.push_back(1'b0);
    exp_a.push_back(bus.CmdOpAxDI);
    exp_b.push_back(bus.CmdOpBxDI);
    step();
    bus.CmdValidxSI = 1'b0;
    bus.ReqReadyxSI = 1'b1;
    step();
    bus.ReqReadyxSI = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("rstw_req_valid", 64'(bus.ReqValidxSO), 64'd0);
    chk("rstw_res_valid", 64'(bus.ResValidxSO), 64'd0);
    chk("rstw_req_in", {bus.ReqIn1xDO[31:0], bus.ReqIn2xDO[31:0]}, 64'd0);
    chk("rstw_random", {bus.RandomDOM2xDO, bus.RandomDOM1xDO}, 64'd0);
    chk("rstw_cmd_ready", 64'(bus.CmdReadyxSO), 64'd0);
    step();
    rst_n = 1'b1;
    bus.RespValidxSI = 1'b1;
    bus.RespResultxDI = {$urandom, $urandom};
    step();
    bus.RespValidxSI = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rstw_no_result", 64'(bus.ResValidxSO), 64'd0);
      chk("rstw_unseeded", 64'(bus.CmdReadyxSO), 64'd0);
      step();
    end

    // Recovery after reseeding
    seed_all({32'h0F1E_2D3C, 32'h4B5A_6978});
    run_txn(1'b0, mask(32'hFFFF_FFFF), mask(32'd1), 1, 3, 1);
    repeat (4) step();
    chk("scoreboard_drain", 64'(exp_a.size() + exp_res.size() + exp_val.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/masked_arith_requester.md
MASKED_ARITH_REQUESTER -- requirements
Module: masked_arith_requester

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, operand width per share; 32 is the only supported value.
REQ-002 SHALL have parameter SHARES, default 2, number of DOM shares; SHARES >= 2.
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum cycles spent in WAIT; TIMEOUT >= 2.
REQ-004 SHALL define RWIDTH = DWIDTH*SHARES*(SHARES-1)/2.
REQ-005 SHALL have the ports listed below.
- ClkxCI  in  1  single clock; all state changes on the rising edge.
- RstxBI  in  1  reset, asynchronous, active-low.
- SeedValidxSI  in  1  load the PRNG seed this cycle.
- SeedxDI  in  2*RWIDTH  PRNG seed.
- CmdValidxSI / CmdReadyxSO  in/out  1  upstream command handshake.
- CmdSubtractxSI  in  1  0 = add, 1 = subtract.
- CmdOpAxDI, CmdOpBxDI  in  DWIDTH*SHARES  shared operands; share j is at bits [DWIDTH*j +: DWIDTH].
- ReqValidxSO / ReqReadyxSI  out/in  1  request handshake to the masked adder.
- ReqSubtractxSO  out  1  registered subtract flag.
- ReqIn1xDO, ReqIn2xDO  out  DWIDTH*SHARES  registered operands A and B.
- RandomDOM1xDO, RandomDOM2xDO  out  RWIDTH each  fresh DOM randomness.
- RespValidxSI  in  1  adder result valid; a single-cycle pulse.
- RespResultxDI  in  DWIDTH*SHARES  adder result shares.
- ResValidxSO / ResReadyxSI  out/in  1  downstream result handshake.
- ResResultxDO  out  DWIDTH*SHARES  registered result shares.
- ErrTimeoutxSO  out  1  sticky timeout flag.
- ErrProtocolxSO  out  1  sticky flag for an unexpected response.
- ErrClearxSI  in  1  clears both error flags.

Function
REQ-006 SHALL implement the FSM states IDLE, ISSUE, WAIT and DONE.
REQ-007 SHALL drive CmdReadyxSO = (state == IDLE) && Seeded, combinationally.
REQ-008 In IDLE, when CmdValidxSI && CmdReadyxSO, SHALL register the operands and the subtract flag and move to ISSUE.
REQ-009 SHALL drive ReqValidxSO = 1 exactly while in ISSUE, and SHALL hold ReqIn1xDO, ReqIn2xDO and ReqSubtractxSO stable until the handshake completes.
REQ-010 In ISSUE, when ReqReadyxSI = 1, SHALL move to WAIT and clear the timeout counter.
REQ-011 In WAIT, SHALL increment the timeout counter every cycle.
REQ-012 In WAIT, when RespValidxSI = 1, SHALL register RespResultxDI into ResResultxDO and move to DONE.
REQ-013 In WAIT, when the counter equals TIMEOUT-1 and RespValidxSI = 0, SHALL set ErrTimeoutxSO and move to IDLE.
- If RespValidxSI = 1 on that same cycle, the response wins and ErrTimeoutxSO is not set.
REQ-014 SHALL drive ResValidxSO = 1 exactly while in DONE, and SHALL move to IDLE on ResReadyxSI = 1.
REQ-015 SHALL treat RespValidxSI = 1 in IDLE, ISSUE or DONE as a protocol error.
- Sets ErrProtocolxSO.
- The data is ignored.
- The state is unchanged.
REQ-016 ErrClearxSI SHALL clear both error flags; a set event in the same cycle SHALL take priority over the clear.
REQ-017 The PRNG SHALL be a 2*RWIDTH-bit register made of 32-bit words.
- Each word is a xorshift32 generator: x ^= x<<13; x ^= x>>17; x ^= x<<5.
- Every word advances every cycle while Seeded = 1 and SeedValidxSI = 0.
REQ-018 The PRNG outputs SHALL map as follows:
- RandomDOM1xDO = PRNG[RWIDTH-1:0].
- RandomDOM2xDO = PRNG[2*RWIDTH-1:RWIDTH].
- Both are driven directly from the PRNG register.
REQ-019 When SeedValidxSI = 1, in any state, SHALL load SeedxDI into the PRNG and set Seeded.
- Any all-zero 32-bit seed word is loaded as 0x00000001.
REQ-020 No datapath register SHALL combine shares.
- No unmasked value of any operand or result is ever formed inside the block.

Reset
REQ-021 While RstxBI = 0, SHALL asynchronously force the following:
- state = IDLE, Seeded = 0, counter = 0, PRNG = 0.
- All registered outputs = 0, including ReqValidxSO, ResValidxSO and both error flags.
REQ-022 A reset asserted mid-transaction SHALL abort it with no response or result emitted; after release, CmdReadyxSO stays 0 until a seed is loaded.

Verification
REQ-023 Unseeded: reset, then CmdValidxSI = 1 for 10 cycles -> CmdReadyxSO = 0 and ReqValidxSO = 0 throughout.
REQ-024 Add: seed 0x1..., A shares {0xA5A5A5A5, 0xA5A5A5A0} (value 5), B shares {0x0F0F0F0F, 0x0F0F0F0C} (value 3), Subtract = 0, ReqReadyxSI held 0 for 3 cycles; the model returns shares of 8 after 5 cycles.
- Expected: ReqIn1xDO/ReqIn2xDO stay stable while stalled.
- Expected: ResResultxDO equals the returned shares and XORs to 0x00000008.
REQ-025 Timeout: TIMEOUT = 4, the model never responds -> ErrTimeoutxSO = 1 on the 4th WAIT cycle and the state returns to IDLE; ErrClearxSI pulse -> flag = 0.
REQ-026 Protocol: RespValidxSI pulse while in IDLE -> ErrProtocolxSO = 1, no state change, ResValidxSO = 0.
REQ-027 PRNG: seed word 0 = 0x00000000 -> the next RandomDOM1xDO word 0 = xorshift32(0x00000001) = 0x00042021, and it advances every cycle.
REQ-028 Reset in WAIT: RstxBI = 0 mid-WAIT -> all outputs = 0 immediately, with no ResValidxSO after release.
